// File: rtl/stream_arb_mux_pkg.sv
// Shared constants and helpers for the streaming arbiter/multiplexer.
// Arbitration modes are plain integers so they can be used directly as parameter values.
package mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    localparam int ARB_EXT   = 2;

    typedef enum logic [1:0] {
        MODE_RR    = 2'd0,
        MODE_FIXED = 2'd1,
        MODE_EXT   = 2'd2,
        MODE_RSVD  = 2'd3
    } arb_mode_e;

    function automatic int sel_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    function automatic arb_mode_e to_mode(input int m);
        case (m)
            ARB_RR:    return MODE_RR;
            ARB_FIXED: return MODE_FIXED;
            ARB_EXT:   return MODE_EXT;
            default:   return MODE_RSVD;
        endcase
    endfunction

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last winner.
// The pointer only moves when the caller reports an accepted transfer.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 5,
    localparam int IW = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] grant_idx_in,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_r;
    logic          hi_found_s;
    logic          lo_found_s;
    logic [IW-1:0] hi_idx_s;
    logic [IW-1:0] lo_idx_s;

    // Last-winner pointer; reset points at N-1 so channel 0 leads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= IW'(N - 1);
        end else if (advance) begin
            ptr_r <= grant_idx_in;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Lowest requester above the pointer, else lowest overall (wrap-around).
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_found_s = 1'b1;
                lo_idx_s   = IW'(j);
                if (j > int'(ptr_r)) begin
                    hi_found_s = 1'b1;
                    hi_idx_s   = IW'(j);
                end else begin
                    hi_found_s = hi_found_s;
                end
            end else begin
                lo_found_s = lo_found_s;
            end
        end
    end

    // Expand the winning index into a one-hot grant.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (hi_found_s) begin
            grant_idx = hi_idx_s;
        end else if (lo_found_s) begin
            grant_idx = lo_idx_s;
        end else begin
            grant_idx = '0;
        end
        for (int j = 0; j < N; j++) begin
            if ((hi_found_s || lo_found_s) && (grant_idx == IW'(j))) begin
                grant[j] = 1'b1;
            end else begin
                grant[j] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// N-input valid/ready multiplexer with a one-entry registered output stage.
// Arbitration policy is fixed at elaboration by ARB_MODE.
module stream_arb_mux
    import mux_pkg::*;
#(
    parameter int NUM_INPUTS = 5,
    parameter int WIDTH      = 4,
    parameter int ARB_MODE   = 0,
    localparam int SEL_W     = sel_width(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    output logic [NUM_INPUTS-1:0]       in_ready,
    input  logic [SEL_W-1:0]            sel,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_idx,
    input  logic                        out_ready,
    output logic                        sel_err
);

    localparam arb_mode_e MODE   = to_mode(ARB_MODE);
    localparam logic      EXT_ON = (MODE == MODE_EXT);

    logic [NUM_INPUTS-1:0] grant_s;
    logic [SEL_W-1:0]      grant_idx_s;
    logic                  load_s;
    logic                  xfer_s;
    logic [WIDTH-1:0]      data_s;
    logic                  out_valid_r;
    logic [WIDTH-1:0]      out_data_r;
    logic [SEL_W-1:0]      out_idx_r;
    logic                  sel_err_r;

    generate
        if (NUM_INPUTS == 1) begin : g_single
            // A single channel needs no arbitration in any mode.
            always_comb begin
                grant_s     = in_valid;
                grant_idx_s = '0;
            end
        end else if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(.N(NUM_INPUTS)) u_rr (
                .clk          (clk),
                .rst_n        (rst_n),
                .req          (in_valid),
                .advance      (xfer_s),
                .grant_idx_in (grant_idx_s),
                .grant        (grant_s),
                .grant_idx    (grant_idx_s)
            );
        end else if (MODE == MODE_FIXED) begin : g_fixed
            // Descending scan so the lowest valid index is written last and wins.
            always_comb begin
                grant_s     = '0;
                grant_idx_s = '0;
                for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        grant_s     = '0;
                        grant_s[i]  = 1'b1;
                        grant_idx_s = SEL_W'(i);
                    end else begin
                        grant_idx_s = grant_idx_s;
                    end
                end
            end
        end else begin : g_ext
            // Out-of-range sel matches no channel, so it naturally yields no grant.
            always_comb begin
                grant_s     = '0;
                grant_idx_s = '0;
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if ((sel == SEL_W'(i)) && in_valid[i]) begin
                        grant_s[i]  = 1'b1;
                        grant_idx_s = SEL_W'(i);
                    end else begin
                        grant_s[i]  = 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign load_s   = !out_valid_r || out_ready;
    assign in_ready = grant_s & {NUM_INPUTS{load_s & rst_n}};
    assign xfer_s   = |(in_ready & in_valid);

    // Data path select driven by the one-hot grant.
    always_comb begin
        data_s = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_s[i]) begin
                data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                data_s = data_s;
            end
        end
    end

    // Output register: load on transfer, drain to empty when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
        end else if (load_s) begin
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= data_s;
                out_idx_r   <= grant_idx_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Registered range flag for the external select input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= EXT_ON && (int'(sel) >= NUM_INPUTS);
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: round-robin, fixed, external-select and single-channel builds.
// Expected values are hand-derived constants in the step sequence.
module tb_stream_arb_mux;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Instance A: round-robin, 5 x 4 bits
    logic [4:0]  a_valid, a_ready;
    logic [19:0] a_data;
    logic [2:0]  a_sel, a_oi;
    logic        a_ov, a_or, a_err;
    logic [3:0]  a_od;
    // Instance B: fixed priority
    logic [4:0]  b_valid, b_ready;
    logic [19:0] b_data;
    logic [2:0]  b_sel, b_oi;
    logic        b_ov, b_or, b_err;
    logic [3:0]  b_od;
    // Instance C: external select
    logic [4:0]  c_valid, c_ready;
    logic [19:0] c_data;
    logic [2:0]  c_sel, c_oi;
    logic        c_ov, c_or, c_err;
    logic [3:0]  c_od;
    // Instance D: single channel, 8 bits
    logic [0:0]  d_valid, d_ready;
    logic [7:0]  d_data, d_od;
    logic [0:0]  d_sel, d_oi;
    logic        d_ov, d_or, d_err;

    stream_arb_mux #(.NUM_INPUTS(5), .WIDTH(4), .ARB_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
        .sel(a_sel), .out_valid(a_ov), .out_data(a_od), .out_idx(a_oi), .out_ready(a_or), .sel_err(a_err));
    stream_arb_mux #(.NUM_INPUTS(5), .WIDTH(4), .ARB_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
        .sel(b_sel), .out_valid(b_ov), .out_data(b_od), .out_idx(b_oi), .out_ready(b_or), .sel_err(b_err));
    stream_arb_mux #(.NUM_INPUTS(5), .WIDTH(4), .ARB_MODE(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
        .sel(c_sel), .out_valid(c_ov), .out_data(c_od), .out_idx(c_oi), .out_ready(c_or), .sel_err(c_err));
    stream_arb_mux #(.NUM_INPUTS(1), .WIDTH(8), .ARB_MODE(0)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_valid), .in_data(d_data), .in_ready(d_ready),
        .sel(d_sel), .out_valid(d_ov), .out_data(d_od), .out_idx(d_oi), .out_ready(d_or), .sel_err(d_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        a_valid = 5'h1F; a_data = 20'h54321; a_sel = 3'd0; a_or = 1'b1;
        b_valid = 5'h00; b_data = 20'h54321; b_sel = 3'd0; b_or = 1'b1;
        c_valid = 5'h00; c_data = 20'h54321; c_sel = 3'd0; c_or = 1'b1;
        d_valid = 1'b0;  d_data = 8'hA5;     d_sel = 1'b0; d_or = 1'b1;
        tick();
        tick();
        chk("rst_a_ov",    32'(a_ov),    32'd0);
        chk("rst_a_od",    32'(a_od),    32'd0);
        chk("rst_a_oi",    32'(a_oi),    32'd0);
        chk("rst_a_err",   32'(a_err),   32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);

        // Round-robin rotation with all channels valid
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 32'(a_ready), 32'h01);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_rot_ov", 32'(a_ov), 32'd1);
            chk("rr_rot_oi", 32'(a_oi), 32'(k % 5));
            chk("rr_rot_od", 32'(a_od), 32'((k % 5) + 1));
        end

        // Stall while channel 2 word is held
        tick();
        chk("rr_pre_oi", 32'(a_oi), 32'd1);
        tick();
        chk("rr_hold_od0", 32'(a_od), 32'h3);
        a_or = 1'b0;
        #1;
        chk("rr_stall_ready", 32'(a_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rr_stall_ov",    32'(a_ov),    32'd1);
            chk("rr_stall_od",    32'(a_od),    32'h3);
            chk("rr_stall_oi",    32'(a_oi),    32'd2);
            chk("rr_stall_rdy",   32'(a_ready), 32'd0);
        end
        a_or = 1'b1;
        #1;
        chk("rr_release_ready", 32'(a_ready), 32'h08);
        tick();
        chk("rr_release_oi", 32'(a_oi), 32'd3);
        chk("rr_release_od", 32'(a_od), 32'h4);
        a_valid = 5'h00;
        tick();
        chk("rr_drain_ov", 32'(a_ov), 32'd0);
        chk("rr_drain_od", 32'(a_od), 32'h4);
        chk("rr_drain_oi", 32'(a_oi), 32'd3);

        // Fixed priority
        b_valid = 5'b10110;
        #1;
        chk("fx_ready1", 32'(b_ready), 32'h02);
        tick();
        chk("fx_oi1", 32'(b_oi), 32'd1);
        chk("fx_od1", 32'(b_od), 32'h2);
        b_valid = 5'b10100;
        #1;
        chk("fx_ready2", 32'(b_ready), 32'h04);
        tick();
        chk("fx_oi2",  32'(b_oi),  32'd2);
        chk("fx_od2",  32'(b_od),  32'h3);
        chk("fx_err",  32'(b_err), 32'd0);

        // External select, including an out-of-range sel
        c_valid = 5'b01000; c_sel = 3'd3;
        #1;
        chk("ex_ready3", 32'(c_ready), 32'h08);
        tick();
        chk("ex_ov1",  32'(c_ov),  32'd1);
        chk("ex_od1",  32'(c_od),  32'h4);
        chk("ex_oi1",  32'(c_oi),  32'd3);
        chk("ex_err0", 32'(c_err), 32'd0);
        c_sel = 3'd6;
        #1;
        chk("ex_ready_bad", 32'(c_ready), 32'd0);
        tick();
        chk("ex_ov_drop", 32'(c_ov),  32'd0);
        chk("ex_err1",    32'(c_err), 32'd1);
        chk("ex_od_keep", 32'(c_od),  32'h4);
        c_sel = 3'd3;
        tick();
        chk("ex_err_clr", 32'(c_err), 32'd0);
        chk("ex_ov_back", 32'(c_ov),  32'd1);

        // Reset while a stalled word is held; pointer sits at 0 beforehand
        a_valid = 5'h1F;
        tick();
        chk("rs_pre_oi4", 32'(a_oi), 32'd4);
        tick();
        chk("rs_pre_oi0", 32'(a_oi), 32'd0);
        a_or = 1'b0;
        tick();
        chk("rs_held_ov", 32'(a_ov), 32'd1);
        chk("rs_held_od", 32'(a_od), 32'h1);
        a_or  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rs_ready_in_rst", 32'(a_ready), 32'd0);
        tick();
        chk("rs_ov", 32'(a_ov), 32'd0);
        chk("rs_od", 32'(a_od), 32'd0);
        chk("rs_oi", 32'(a_oi), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rs_first_ready", 32'(a_ready), 32'h01);
        tick();
        chk("rs_first_oi", 32'(a_oi), 32'd0);
        chk("rs_first_od", 32'(a_od), 32'h1);
        a_valid = 5'h00;

        // Single-channel build
        #1;
        chk("one_ready_idle", 32'(d_ready), 32'd0);
        chk("one_ov_idle",    32'(d_ov),    32'd0);
        d_valid = 1'b1;
        #1;
        chk("one_ready", 32'(d_ready), 32'd1);
        tick();
        chk("one_ov1", 32'(d_ov), 32'd1);
        chk("one_od1", 32'(d_od), 32'hA5);
        chk("one_oi1", 32'(d_oi), 32'd0);
        d_valid = 1'b0;
        tick();
        chk("one_nodup", 32'(d_ov), 32'd0);
        d_valid = 1'b1; d_data = 8'h5A;
        tick();
        chk("one_ov2", 32'(d_ov), 32'd1);
        chk("one_od2", 32'(d_od), 32'h5A);
        d_or = 1'b0; d_data = 8'h33;
        #1;
        chk("one_stall_ready", 32'(d_ready), 32'd0);
        tick();
        chk("one_stall_od", 32'(d_od), 32'h5A);
        d_or = 1'b1;
        #1;
        chk("one_release_ready", 32'(d_ready), 32'd1);
        tick();
        chk("one_od3", 32'(d_od), 32'h33);
        d_valid = 1'b0;
        tick();
        chk("one_ov_end", 32'(d_ov),  32'd0);
        chk("one_err",    32'(d_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
